rgb_sequencer: RTL and testbench
================================

# rgb_sequencer

Programmable colour-pattern controller for the board RGB LED. It holds a small table of colour/duration steps written over a simple config port and plays them out on the three LED pins under start/stop control, optionally looping. It sits between the fabric's control logic and the `RGB_R/G/B` pins, replacing free-running hard-coded blink chains.

## Interface
- `TICK_CYCLES`, default 2000000: clock cycles per duration tick (0.166 s at 12 MHz); must be ≥ 2.
- `STEPS`, default 8: table depth; power of two, ≥ 2.
- `DUR_W`, default 4: width of the per-step duration field, in ticks.
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `cfg_we`, in, 1: table write strobe; accepted only when `busy`=0.
- `cfg_addr`, in, $clog2(STEPS): table entry index.
- `cfg_color`, in, 3: {R,G,B} for the entry.
- `cfg_dur`, in, DUR_W: duration in ticks; 0 is treated as 1.
- `cfg_last`, in, 1: entry ends the pattern.
- `cfg_duty`, in, 4: brightness; used only with `RGB_SEQ_PWM_EN`.
- `start`, in, 1: single-cycle pulse that begins playback at entry 0.
- `stop`, in, 1: single-cycle pulse that aborts playback.
- `loop`, in, 1: sampled on accepted `start`; 1 means repeat forever.
- `busy`, out, 1: playback active.
- `done`, out, 1: one-cycle pulse on natural pattern completion.
- `step_idx`, out, $clog2(STEPS): entry currently displayed.
- `RGB_R`, `RGB_G`, `RGB_B`, out, 1 each: LED drive, registered.

## Operation
- Reset:
  - All outputs 0. FSM in IDLE.
  - Every table entry becomes colour 000, dur 1, last 0, duty 15.
- FSM states:
  - IDLE: LEDs 000. `start` (with `stop`=0) latches `loop`, loads entry 0 and enters RUN.
  - RUN: displays the current entry. After max(dur,1) ticks, either:
    - advances to idx+1, or
    - if the entry has last=1 or idx=STEPS-1: with loop latched, wraps to 0; otherwise enters DONE.
  - DONE: one cycle. `done`=1, LEDs 000, `busy`=0, then returns to IDLE.
- `stop` in RUN: next state IDLE, LEDs 000, `busy`=0. No `done` pulse.
- `start` while `busy`: ignored. `start` and `stop` in the same cycle: `stop` wins.
- `cfg_we` while `busy`=1: dropped silently; the table is unchanged.
- Duration arithmetic:
  - The tick prescaler clears on every step entry, so step timing has no phase error.
  - The duration counter is DUR_W bits wide and compares against max(dur,1).

## Timing
- `start` accepted at edge t:
  - `busy`=1 and the entry-0 colour are visible from t+1.
  - `step_idx`=0.
- Each step is visible for exactly max(dur,1)×TICK_CYCLES cycles.
- Consecutive steps, including the loop wrap, are contiguous with no off cycle between them.
- Last step of a non-looping pattern:
  - Final colour cycle at edge e. `done`=1 and LEDs 000 at e+1; `busy`=0 at e+1.
- `stop` at edge s: LEDs 000 and `busy`=0 from s+1.
- Config write at edge w: the entry is readable by playback starting at w+1 or later.
- `rst` asserted mid-run: outputs go to 0 asynchronously and the table is reinitialised.

## Configuration
- `RGB_SEQ_PWM_EN` defined:
  - Each entry also stores `cfg_duty`. A free-running 4-bit PWM counter runs.
  - An enabled channel is driven high when pwm_cnt < duty; duty 15 means always on, duty 0 means off.
- `RGB_SEQ_PWM_EN` undefined:
  - `cfg_duty` is ignored and no duty storage exists.
  - Enabled channels are driven high for the whole step.

## Structure
- Package `rgb_seq_pkg`:
  - `rgb_t` packed {r,g,b}.
  - `seq_state_t` enum {IDLE, RUN, DONE}.
  - Entry struct `seq_entry_t`.
  - Constants `RGB_OFF`, `RGB_RED`, `RGB_GREEN`, `RGB_BLUE`.
- Sub-module `rgb_tick_gen`:
  - Parameter TICK_CYCLES; inputs `clk`, `rst`, `clear`; output `tick`.
  - `tick` is a one-cycle pulse when the count is TICK_CYCLES-1; `clear` restarts the count.

## Test plan
All scenarios use TICK_CYCLES=4 and STEPS=8.
- Directed playback:
  - Stimulus: entry0 = 100/dur2, entry1 = 010/dur1/last; `start` with `loop`=0.
  - Response: 100 for 8 cycles, 010 for 4 cycles, then 000 with a single `done` pulse; `busy` drops the same cycle.
- Loop and stop:
  - Stimulus: same table with `loop`=1; `stop` during the second pass.
  - Response: 100/010 alternate with no gap cycles, `step_idx` 0/1; after `stop`, 000 next cycle, no `done`.
- Zero duration and wrap:
  - Stimulus: every entry dur 0, none marked last, `loop`=0.
  - Response: each entry shows for 4 cycles; `done` after 32 cycles.
- Collisions:
  - Stimulus: `cfg_we` while busy, `start` while busy, `start`+`stop` together in IDLE.
  - Response: table unchanged, playback unaffected, FSM stays IDLE.
- Reset:
  - Stimulus: assert `rst` mid-step, between clock edges.
  - Response: LEDs, `busy` and `done` go to 0 immediately; a following `start` shows colour 000 and no step is ever marked last.
- PWM (`RGB_SEQ_PWM_EN` defined):
  - Stimulus: entry 111/duty4, then duty 0, then duty 15.
  - Response: 4 of every 16 cycles high, then constant 0, then constant 1.

Source files
------------

// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg: shared types, colour constants and helpers for the RGB pattern sequencer.
package rgb_seq_pkg;

  // One LED colour, MSB first: {r,g,b}
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Widest duration field a table entry view can carry
  localparam int SEQ_DUR_MAX_W = 16;

  // Duty value meaning "always on"
  localparam logic [3:0] DUTY_FULL = 4'hF;

  // Decoded view of one table entry
  typedef struct packed {
    rgb_t                     color;
    logic [SEQ_DUR_MAX_W-1:0] dur;
    logic                     last;
    logic [3:0]               duty;
  } seq_entry_t;

  localparam rgb_t RGB_OFF   = rgb_t'(3'b000);
  localparam rgb_t RGB_RED   = rgb_t'(3'b100);
  localparam rgb_t RGB_GREEN = rgb_t'(3'b010);
  localparam rgb_t RGB_BLUE  = rgb_t'(3'b001);

  // A stored duration of zero plays as one tick
  function automatic logic [SEQ_DUR_MAX_W-1:0] eff_dur(input logic [SEQ_DUR_MAX_W-1:0] dur);
    return (dur == '0) ? SEQ_DUR_MAX_W'(1) : dur;
  endfunction

  // Mask a colour by brightness: on while phase < duty, duty 15 never blanks
  function automatic logic [2:0] pwm_gate(input rgb_t color, input logic [3:0] duty,
                                          input logic [3:0] phase);
    logic on;
    on = (duty == DUTY_FULL) || (phase < duty);
    return color & {3{on}};
  endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// rgb_tick_gen: prescaler producing a one-cycle tick every TICK_CYCLES clocks.
// 'clear' restarts the count so a new step starts on a whole tick boundary.
module rgb_tick_gen #(
  parameter int TICK_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == CNT_W'(TICK_CYCLES - 1));

  // Count 0..TICK_CYCLES-1, wrapping on the tick or restarting on clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rgb_sequencer.sv
// rgb_sequencer: plays a small table of colour/duration steps on the RGB LED pins.
// Optional feature macro: RGB_SEQ_PWM_EN adds a per-entry 4-bit duty (brightness)
// and a free-running PWM counter; without it channels are fully on for a step.
module rgb_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int TICK_CYCLES = 2000000,
  parameter int STEPS       = 8,
  parameter int DUR_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(STEPS)-1:0] cfg_addr,
  input  logic [2:0]               cfg_color,
  input  logic [DUR_W-1:0]         cfg_dur,
  input  logic                     cfg_last,
  input  logic [3:0]               cfg_duty,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     RGB_R,
  output logic                     RGB_G,
  output logic                     RGB_B
);

  localparam int                IDX_W    = $clog2(STEPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  // Pattern table (flops, so reset can restore the default entries)
  rgb_t             r_tab_color [STEPS];
  logic [DUR_W-1:0] r_tab_dur   [STEPS];
  logic [STEPS-1:0] r_tab_last;

  // Playback state and registered outputs
  seq_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [DUR_W-1:0] r_dur_cnt;
  logic             r_loop;
  logic [2:0]       r_led;
  logic             r_busy;
  logic             r_done;

  logic             w_wr_en;
  logic             w_tick;
  logic             w_clear;
  logic             w_step_end;
  logic             w_is_final;
  logic [IDX_W-1:0] w_succ_idx;
  logic [IDX_W-1:0] w_load_idx;
  seq_entry_t       w_cur;
  rgb_t             w_nxt_color;
  logic [3:0]       w_nxt_duty;
  logic [3:0]       w_phase;
  logic [2:0]       w_cur_led;
  logic [2:0]       w_nxt_led;

`ifdef RGB_SEQ_PWM_EN
  logic [3:0] r_tab_duty [STEPS];
  logic [3:0] r_pwm_cnt;

  // Table duty storage, written alongside the rest of the entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        r_tab_duty[i] <= DUTY_FULL;
      end
    end else if (w_wr_en) begin
      r_tab_duty[cfg_addr] <= cfg_duty;
    end
  end

  // Free-running brightness phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
    end
  end

  assign w_phase    = r_pwm_cnt;
  assign w_nxt_duty = r_tab_duty[w_load_idx];
`else
  // Brightness is fixed at full; the duty input has no effect in this build
  logic w_unused_duty;
  assign w_unused_duty = ^cfg_duty;
  assign w_phase       = 4'd0;
  assign w_nxt_duty    = DUTY_FULL;
`endif

  // The table only changes while nothing is playing it
  assign w_wr_en = cfg_we && !r_busy;

  // Table colour/duration/last storage; reset restores off, 1 tick, not last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        r_tab_color[i] <= RGB_OFF;
        r_tab_dur[i]   <= DUR_W'(1);
        r_tab_last[i]  <= 1'b0;
      end
    end else if (w_wr_en) begin
      r_tab_color[cfg_addr] <= rgb_t'(cfg_color);
      r_tab_dur[cfg_addr]   <= cfg_dur;
      r_tab_last[cfg_addr]  <= cfg_last;
    end
  end

  // Decode the entry on display
  always_comb begin
    w_cur       = '0;
    w_cur.color = r_tab_color[r_idx];
    w_cur.dur   = SEQ_DUR_MAX_W'(r_tab_dur[r_idx]);
    w_cur.last  = r_tab_last[r_idx];
`ifdef RGB_SEQ_PWM_EN
    w_cur.duty  = r_tab_duty[r_idx];
`else
    w_cur.duty  = DUTY_FULL;
`endif
  end

  // Successor: wrap to entry 0 after a last-marked or final table entry
  assign w_is_final = w_cur.last || (r_idx == LAST_IDX);
  assign w_succ_idx = w_is_final ? '0 : r_idx + IDX_W'(1);
  // From IDLE the next entry loaded is always entry 0
  assign w_load_idx = (r_state == RUN) ? w_succ_idx : '0;

  assign w_nxt_color = r_tab_color[w_load_idx];
  assign w_cur_led   = pwm_gate(w_cur.color, w_cur.duty, w_phase);
  assign w_nxt_led   = pwm_gate(w_nxt_color, w_nxt_duty, w_phase);

  // A step ends on the tick that completes its max(dur,1)-th tick
  assign w_step_end = (r_state == RUN) && w_tick &&
                      ((SEQ_DUR_MAX_W'(r_dur_cnt) + SEQ_DUR_MAX_W'(1)) >= eff_dur(w_cur.dur));
  // Hold the prescaler at zero outside RUN and restart it on every step entry
  assign w_clear    = (r_state != RUN) || w_step_end;

  rgb_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  // Playback FSM with registered LED, busy, done and index outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_dur_cnt <= '0;
      r_loop    <= 1'b0;
      r_led     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_state   <= RUN;
            r_loop    <= loop;
            r_idx     <= '0;
            r_dur_cnt <= '0;
            r_busy    <= 1'b1;
            r_led     <= w_nxt_led;
          end
        end
        RUN: begin
          if (stop) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_dur_cnt <= '0;
            r_busy    <= 1'b0;
            r_led     <= '0;
          end else if (w_step_end) begin
            r_dur_cnt <= '0;
            if (w_is_final && !r_loop) begin
              r_state <= DONE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_led   <= '0;
            end else begin
              r_idx <= w_load_idx;
              r_led <= w_nxt_led;
            end
          end else begin
            if (w_tick) begin
              r_dur_cnt <= r_dur_cnt + DUR_W'(1);
            end
            r_led <= w_cur_led;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_led   <= '0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign step_idx = r_idx;
  assign RGB_R    = r_led[2];
  assign RGB_G    = r_led[1];
  assign RGB_B    = r_led[0];

endmodule

// File: tb/tb_rgb_sequencer.sv
// tb_rgb_sequencer: scoreboard bench for rgb_sequencer (TICK_CYCLES=4, STEPS=8).
// Stimulus pushes per-cycle expectations derived from a table model; a monitor
// on the falling edge pops and compares them. Define RGB_SEQ_PWM_EN for the PWM check.
module tb_rgb_sequencer;
  import rgb_seq_pkg::*;

  localparam int TICK  = 4;
  localparam int STEPS = 8;
  localparam int DUR_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [2:0] cfg_color = '0;
  logic [3:0] cfg_dur = '0;
  logic       cfg_last = 1'b0;
  logic [3:0] cfg_duty = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_i = 1'b0;
  logic       busy, done, RGB_R, RGB_G, RGB_B;
  logic [2:0] step_idx;

  rgb_sequencer #(.TICK_CYCLES(TICK), .STEPS(STEPS), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_color(cfg_color),
    .cfg_dur(cfg_dur), .cfg_last(cfg_last), .cfg_duty(cfg_duty), .start(start),
    .stop(stop), .loop(loop_i), .busy(busy), .done(done), .step_idx(step_idx),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference table model
  logic [2:0] m_color [STEPS];
  int         m_dur   [STEPS];
  bit         m_last  [STEPS];

  typedef struct {
    int         cyc;
    logic [2:0] rgb;
    logic       busy;
    logic       done;
    int         idx;
    bit         chk_idx;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      n_checks++;
      if (e.cyc != cyc_cnt || {RGB_R, RGB_G, RGB_B} !== e.rgb || busy !== e.busy ||
          done !== e.done || (e.chk_idx && int'(step_idx) != e.idx)) begin
        n_fail++;
        $display("FAIL cycle_check cyc=%0d (due %0d) got rgb=%b busy=%b done=%b idx=%0d required rgb=%b busy=%b done=%b idx=%0d",
                 cyc_cnt, e.cyc, {RGB_R, RGB_G, RGB_B}, busy, done, step_idx,
                 e.rgb, e.busy, e.done, e.idx);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] rgb, input logic b, input logic d,
                      input int idx, input bit ci);
    exp_t e;
    e.cyc = c; e.rgb = rgb; e.busy = b; e.done = d; e.idx = idx; e.chk_idx = ci;
    q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < STEPS; i++) begin
      m_color[i] = 3'b000; m_dur[i] = 1; m_last[i] = 1'b0;
    end
  endtask

  function automatic logic [3:0] tb_duty();
`ifdef RGB_SEQ_PWM_EN
    return 4'hF;
`else
    return 4'($urandom);
`endif
  endfunction

  // Write one entry while idle and mirror it into the model
  task automatic write_entry(input int a, input logic [2:0] col, input int d, input bit l,
                             input logic [3:0] duty);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_color = col; cfg_dur = 4'(d);
    cfg_last = l; cfg_duty = duty;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_color[a] = col; m_dur[a] = d; m_last[a] = l;
    $display("write addr=%0d color=%b dur=%0d last=%0d", a, col, d, l);
  endtask

  // Expected timeline of a playback whose start is taken at edge t
  task automatic build(input int t, input bit lp, input int stop_at, output int end_c);
    int c, idx, limit, len;
    bit fin;
    c = t; idx = 0; fin = 1'b0;
    limit = (stop_at > 0) ? t + stop_at : t + 5000;
    while (!fin && c < limit) begin
      len = ((m_dur[idx] == 0) ? 1 : m_dur[idx]) * TICK;
      for (int k = 0; k < len && c < limit; k++) begin
        push(c, m_color[idx], 1'b1, 1'b0, idx, 1'b1);
        c++;
      end
      if (c < limit) begin
        if (m_last[idx] || idx == STEPS - 1) begin
          if (lp) idx = 0; else fin = 1'b1;
        end else begin
          idx++;
        end
      end
    end
    push(c, 3'b000, 1'b0, fin, 0, 1'b0);
    push(c + 1, 3'b000, 1'b0, 1'b0, 0, 1'b0);
    end_c = c + 1;
  endtask

  // One playback; optional stop, busy-time write and busy-time start (edge offsets from start)
  task automatic play(input string name, input bit lp, input int stop_at, input int we_at,
                      input int restart_at);
    int t, end_c, guard, rel;
    t = cyc_cnt + 1;
    build(t, lp, stop_at, end_c);
    loop_i = lp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; loop_i = 1'b0;
    guard = 0;
    while (cyc_cnt <= end_c && guard < 5000) begin
      rel       = cyc_cnt + 1 - t;
      stop      = (stop_at > 0 && rel == stop_at);
      start     = (restart_at > 0 && rel == restart_at);
      cfg_we    = (we_at > 0 && rel == we_at);
      cfg_addr  = 3'($urandom_range(0, 1));
      cfg_color = 3'($urandom);
      cfg_dur   = 4'($urandom);
      cfg_last  = 1'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    stop = 1'b0; start = 1'b0; cfg_we = 1'b0;
    chk({name, "_drain"}, q.size(), 0);
    $display("play %s loop=%0d stop_at=%0d we_at=%0d restart_at=%0d cycles=%0d",
             name, lp, stop_at, we_at, restart_at, end_c - t + 1);
  endtask

  task automatic idle_expect(input int n);
    int t;
    t = cyc_cnt + 1;
    for (int k = 0; k < n; k++) push(t + k, 3'b000, 1'b0, 1'b0, 0, 1'b0);
    repeat (n + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, hi;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({busy, done, RGB_R, RGB_G, RGB_B, step_idx}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_expect(3);

    // Directed playback
    write_entry(0, RGB_RED, 2, 1'b0, tb_duty());
    write_entry(1, RGB_GREEN, 1, 1'b1, tb_duty());
    play("directed", 1'b0, 0, 0, 0);

    // Loop then stop part way through the second pass
    play("loop_stop", 1'b1, 18, 0, 0);

    // Every entry zero duration, none last: wraps through all eight entries
    for (int a = 0; a < STEPS; a++) write_entry(a, 3'(a + 1), 0, 1'b0, tb_duty());
    play("zero_dur", 1'b0, 0, 0, 0);

    // Writes and starts while busy are ignored; table stays as modelled
    play("collide", 1'b0, 0, 2, 3);
    play("after_collide", 1'b0, 0, 0, 0);

    // start with stop in IDLE: nothing happens
    start = 1'b1; stop = 1'b1;
    t = cyc_cnt + 1;
    for (int k = 0; k < 3; k++) push(t + k, 3'b000, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_stop_drain", q.size(), 0);

    // Randomized tables and playbacks
    for (int it = 0; it < 10; it++) begin
      bit lp;
      for (int a = 0; a < STEPS; a++)
        write_entry(a, 3'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), tb_duty());
      lp = 1'($urandom);
      play("random", lp, lp ? $urandom_range(5, 120) : 0, $urandom_range(0, 3),
           $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a step
    write_entry(0, RGB_BLUE, 3, 1'b0, tb_duty());
    loop_i = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; loop_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrun_busy", int'(busy), 1);
    chk("midrun_color", int'({RGB_R, RGB_G, RGB_B}), int'(m_color[0]));
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({busy, done, RGB_R, RGB_G, RGB_B, step_idx}), 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    $display("reset asserted mid-step at cyc=%0d", cyc_cnt);
    idle_expect(2);
    play("after_reset", 1'b0, 0, 0, 0);

`ifdef RGB_SEQ_PWM_EN
    // Brightness: duty 4, then 0, then 15, each over 32 cycles
    write_entry(0, 3'b111, 8, 1'b0, 4'd4);
    write_entry(1, 3'b111, 8, 1'b0, 4'd0);
    write_entry(2, 3'b111, 8, 1'b1, 4'd15);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      hi = 0;
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        if ({RGB_R, RGB_G, RGB_B} == 3'b111) hi++;
      end
      chk($sformatf("pwm_high_count_step%0d", s), hi, (s == 0) ? 8 : ((s == 1) ? 0 : 32));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pwm_end_busy", int'(busy), 0);
    $display("pwm sequence duty 4/0/15 checked");
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("final_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
